imem: RTL and testbench

IMEM -- requirements
Module: imem

---
 rtl/imem_pkg.sv | 33 +++
 rtl/imem.sv | 51 +++++
 tb/tb_imem.sv | 132 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared constants for the instruction memory: word width, word-address
// width, ROM depth and the program image. The image holds only the words
// that are actually used. The zero-filled tail up to the full depth is built
// inside imem from the depth constant.
// -----------------------------------------------------------------------------
package imem_pkg;

   localparam int IMEM_N        = 32;
   localparam int IMEM_ADDR_W   = 6;
   localparam int IMEM_DEPTH    = 2 ** IMEM_ADDR_W;
   localparam int IMEM_PROG_LEN = 47;

   typedef logic [IMEM_N-1:0] imem_word_t;

   // Program image, word addresses 0x00..0x2E.
   localparam imem_word_t IMEM_PROG [IMEM_PROG_LEN] = '{
      32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
      32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
      32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
      32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
      32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
      32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
      32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
      32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
      32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
      32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
      32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
      32'h8b1003de, 32'hf81f83d9, 32'hb400001f
   };

endpackage : imem_pkg

// File: rtl/imem.sv
// -----------------------------------------------------------------------------
// imem
// Read-only instruction memory of 2**ADDR_W words of N bits. The contents are
// fixed at elaboration and there is no write path. A read returns one
// registered word with one cycle of latency.
//
// Ports
//   clk   : single clock, rising edge active
//   reset : synchronous, active-high; zeroes q and takes priority over reads
//   addr  : word address (entry index, not a byte address)
//   q     : registered instruction word
// -----------------------------------------------------------------------------
module imem
   import imem_pkg::*;
#(
   parameter int N      = IMEM_N,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   output logic [N-1:0]      q
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [N-1:0] rom_s [DEPTH];
   logic [N-1:0] q_r;

   // The program image fills the low entries. Every entry above it is
   // generated as zero from the depth constant.
   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      if (i < IMEM_PROG_LEN) begin : g_prog
         assign rom_s[i] = N'(IMEM_PROG[i]);
      end else begin : g_zero
         assign rom_s[i] = {N{1'b0}};
      end
   end

   // Output register: reset wins, otherwise load the addressed word.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r <= {N{1'b0}};
      end else begin
         q_r <= rom_s[addr];
      end
   end

   assign q = q_r;

endmodule : imem

// File: tb/tb_imem.sv
// -----------------------------------------------------------------------------
// tb_imem
// Self-checking bench for imem. A table-driven model predicts q at every edge.
// Directed steps also pin selected words to literal values.
// -----------------------------------------------------------------------------
module tb_imem;

   logic        clk;
   logic        reset;
   logic [5:0]  addr;
   logic [31:0] q;

   int checks = 0;
   int errors = 0;

   // Reference program image, independent copy of the listing.
   localparam logic [31:0] TAB [47] = '{
      32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
      32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
      32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
      32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
      32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
      32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
      32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
      32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
      32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
      32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
      32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
      32'h8b1003de, 32'hf81f83d9, 32'hb400001f
   };

   imem dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_word(input logic [5:0] a);
      if (int'(a) < 47) return TAB[int'(a)];
      else              return 32'h0000_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: q=%08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model-based compare on every edge: prediction from the sampled inputs.
   logic [31:0] exp_q;
   always @(posedge clk) begin
      exp_q = reset ? 32'h0000_0000 : model_word(addr);
      #1;
      check("model", q, exp_q);
   end

   task automatic drive(input logic [5:0] a, input logic r);
      @(negedge clk);
      addr  = a;
      reset = r;
   endtask

   task automatic expect_q(input string name, input logic [31:0] exp);
      @(posedge clk);
      #1;
      check(name, q, exp);
   endtask

   initial begin
      reset = 1'b1;
      addr  = 6'h00;
      expect_q("reset_state", 32'h0000_0000);
      expect_q("reset_hold", 32'h0000_0000);

      // Sequential sweep 0x00..0x31 with a one-cycle reset pulse at 0x10.
      for (int a = 0; a < 50; a++) begin
         drive(6'(a), (a == 16));
         @(posedge clk);
         #1;
         case (a)
            0:  check("sweep_00", q, 32'hf8000001);
            3:  check("sweep_03", q, 32'h8b050083);
            16: check("midrun_reset_10", q, 32'h0000_0000);
            17: check("after_reset_11", q, 32'h8a140294);
            37: check("sweep_25", q, 32'hb4ffff82);
            46: check("sweep_2e", q, 32'hb400001f);
            49: check("sweep_31", q, 32'h0000_0000);
            default: ;
         endcase
      end

      // One-cycle latency across back-to-back addresses.
      drive(6'h1c, 1'b0);
      expect_q("latency_1c", 32'hf807801f);
      drive(6'h1d, 1'b0);
      expect_q("latency_1d", 32'hb4000040);

      // Reset priority over a read, then recovery on the next edge.
      drive(6'h00, 1'b1);
      expect_q("reset_priority", 32'h0000_0000);
      drive(6'h00, 1'b0);
      expect_q("reset_release", 32'hf8000001);

      // Non-sequential access, including a repeat.
      drive(6'h3f, 1'b0);
      expect_q("rand_3f", 32'h0000_0000);
      drive(6'h2a, 1'b0);
      expect_q("rand_2a", 32'hf85f83d9);
      drive(6'h00, 1'b0);
      expect_q("rand_00", 32'hf8000001);
      drive(6'h2a, 1'b0);
      expect_q("rand_2a_again", 32'hf85f83d9);

      // Random addresses with occasional reset pulses, checked by the model.
      for (int i = 0; i < 400; i++) begin
         drive(6'($urandom_range(0, 63)), ($urandom_range(0, 15) == 0));
      end

      drive(6'h00, 1'b0);
      @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_imem
